// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter that issues one ALU operation at a time and returns the result.
// Optional WAIT timeout is enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
  parameter int W              = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [1:0]     op0,
  input  logic [1:0]     op1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           rsp_valid0,
  output logic           rsp_valid1,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_err,
  output logic           alu_begin_op,
  output logic [1:0]     alu_opcode,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic           alu_done,
  input  logic [2*W-1:0] alu_result
);

  typedef enum logic [2:0] {StIdle, StGrant, StIssue, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic   sel_q, last_q;
  logic   win, timeout, wait_exit;

  // Contention goes to whoever was not served last; a lone request always wins.
  assign win = (req0 & req1) ? ~last_q : req1;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (wait_exit) begin
        err_q <= timeout;
      end
    end
  end

  assign timeout = (state_q == StWait) & alu_opcode[1] & ~alu_done &
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Add/sub finish after a single WAIT cycle regardless of alu_done.
  assign wait_exit = (state_q == StWait) & (~alu_opcode[1] | alu_done | timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req0 | req1) state_d = StGrant;
      StGrant: state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (wait_exit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0 | req1) sel_q <= win;
        end
        StGrant: begin
          alu_opcode <= sel_q ? op1 : op0;
          alu_a      <= sel_q ? a1 : a0;
          alu_b      <= sel_q ? b1 : b0;
        end
        StWait: begin
          if (wait_exit) rsp_result <= timeout ? '0 : alu_result;
        end
        StResp: begin
          last_q <= sel_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt0         = (state_q == StGrant) & ~sel_q;
    gnt1         = (state_q == StGrant) & sel_q;
    alu_begin_op = (state_q == StIssue);
    rsp_valid0   = (state_q == StResp) & ~sel_q;
    rsp_valid1   = (state_q == StResp) & sel_q;
`ifdef ALU_ARB_TIMEOUT_EN
    rsp_err      = (state_q == StResp) & err_q;
`else
    rsp_err      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, hand-written corner sequences and
// randomized transactions against a round-robin/arithmetic reference model.
module tb_alu_arbiter;
  localparam int W  = 8;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [1:0]    op0 = '0, op1 = '0;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, alu_begin_op;
  logic [RW-1:0] rsp_result;
  logic [1:0]    alu_opcode;
  logic [W-1:0]  alu_a, alu_b;
  logic          alu_done;
  logic [RW-1:0] alu_result = '0;
  logic          model_done = 1'b0, stray_done = 1'b0;

  int            total = 0, bad = 0;
  int            last_m = 1;
  int            md_delay = 2;
  int            cnt = 0;
  bit            no_done = 1'b0, force_en = 1'b0;
  logic [RW-1:0] force_val = '0;

  assign alu_done = model_done | stray_done;

  alu_arbiter #(.W(W), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .alu_begin_op(alu_begin_op), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [RW-1:0] x, y;
    x = RW'(a);
    y = RW'(b);
    case (op)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x * y;
      default: return (y == 0) ? '1 : x / y;
    endcase
  endfunction

  // Environment ALU: add/sub answer immediately, mul/div pulse done md_delay cycles after start.
  always @(posedge clk) begin
    #1;
    model_done = 1'b0;
    alu_result = force_en ? force_val : ref_op(alu_opcode, alu_a, alu_b);
    if (reset) cnt = 0;
    else if (alu_begin_op && alu_opcode[1]) cnt = no_done ? 0 : md_delay;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) model_done = 1'b1;
    end
  end

  function automatic logic [63:0] outs();
    return {gnt0, gnt1, rsp_valid0, rsp_valid1, alu_begin_op, rsp_err, alu_opcode, alu_a,
            alu_b, rsp_result};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(output logic [1:0] g, output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n++;
      if (gnt0 | gnt1) break;
    end
    g = {gnt1, gnt0};
  endtask

  task automatic wait_rsp(output logic [1:0] v, output int n, output int dn);
    n  = 0;
    dn = -100;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (alu_done) dn = n;
      if (rsp_valid0 | rsp_valid1) break;
    end
    v = {rsp_valid1, rsp_valid0};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    last_m = 1;
  endtask

  task automatic txn(input string nm, input logic r0, input logic r1, input logic [1:0] o0,
                     input logic [1:0] o1, input logic [W-1:0] x0, input logic [W-1:0] y0,
                     input logic [W-1:0] x1, input logic [W-1:0] y1, input int ew,
                     input logic [RW-1:0] er);
    logic [1:0] g, v, eop;
    int n, dn;
    @(negedge clk);
    req0 = r0; req1 = r1; op0 = o0; op1 = o1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    wait_gnt(g, n);
    chk({nm, " gnt"}, 64'(g), (ew != 0) ? 64'd2 : 64'd1);
    chk({nm, " gnt_lat"}, 64'(n), 64'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " begin_op"}, 64'(alu_begin_op), 64'd1);
    // Operands past the grant cycle must not leak into the result.
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    eop = (ew != 0) ? o1 : o0;
    wait_rsp(v, n, dn);
    chk({nm, " rsp_valid"}, 64'(v), (ew != 0) ? 64'd2 : 64'd1);
    chk({nm, " result"}, 64'(rsp_result), 64'(er));
    chk({nm, " err"}, 64'(rsp_err), 64'd0);
    if (!eop[1]) chk({nm, " g2r_lat"}, 64'(n), 64'd3);
    else chk({nm, " done2rsp"}, 64'(n - dn), 64'd1);
    last_m = ew;
  endtask

  typedef struct {
    logic          r0, r1;
    logic [1:0]    o0, o1;
    logic [W-1:0]  x0, y0, x1, y1;
    int            w;
    logic [RW-1:0] res;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [1:0] g, v;
    int n, dn, ew;
    logic acc;
    logic [1:0] ro0, ro1, rr;
    logic [W-1:0] rx0, ry0, rx1, ry1;

    tbl[0] = '{1'b1, 1'b0, 2'd0, 2'd0, 8'd5,   8'd3,   8'd0,   8'd0,   0, 16'd8};
    tbl[1] = '{1'b1, 1'b1, 2'd2, 2'd3, 8'd3,   8'd4,   8'd200, 8'd10,  1, 16'd20};
    tbl[2] = '{1'b1, 1'b1, 2'd1, 2'd0, 8'd9,   8'd2,   8'd1,   8'd1,   0, 16'd7};
    tbl[3] = '{1'b0, 1'b1, 2'd0, 2'd2, 8'd0,   8'd0,   8'd255, 8'd255, 1, 16'hFE01};
    tbl[4] = '{1'b1, 1'b1, 2'd0, 2'd1, 8'd255, 8'd255, 8'd1,   8'd1,   0, 16'h01FE};
    tbl[5] = '{1'b1, 1'b0, 2'd1, 2'd0, 8'd2,   8'd5,   8'd0,   8'd0,   0, 16'hFFFD};
    tbl[6] = '{1'b1, 1'b1, 2'd3, 2'd3, 8'd100, 8'd7,   8'd9,   8'd3,   1, 16'd3};

    @(negedge clk);
    chk("reset outputs", outs(), 64'd0);
    do_reset();

    // alu_done while idle must not start anything.
    @(negedge clk) stray_done = 1'b1;
    @(negedge clk) stray_done = 1'b0;
    acc = 1'b0;
    repeat (3) begin
      @(negedge clk);
      acc |= gnt0 | gnt1 | rsp_valid0 | rsp_valid1;
    end
    chk("idle done ignored", 64'(acc), 64'd0);

    // Both requesting from reset: 0, then 1, then 0 again.
    md_delay = 3;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; op0 = 2'd2; op1 = 2'd2;
    a0 = 8'd3; b0 = 8'd5; a1 = 8'd7; b1 = 8'd9;
    wait_gnt(g, n);
    chk("rr first gnt", 64'(g), 64'd1);
    wait_rsp(v, n, dn);
    chk("rr first rsp", 64'(v), 64'd1);
    chk("rr first res", 64'(rsp_result), 64'd15);
    wait_gnt(g, n);
    chk("rr second gnt", 64'(g), 64'd2);
    wait_rsp(v, n, dn);
    chk("rr second rsp", 64'(v), 64'd2);
    chk("rr second res", 64'(rsp_result), 64'd63);
    wait_gnt(g, n);
    chk("rr third gnt", 64'(g), 64'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_rsp(v, n, dn);
    chk("rr third res", 64'(rsp_result), 64'd15);
    @(negedge clk);
    chk("result held", 64'(rsp_result), 64'd15);

    do_reset();
    md_delay = 2;
    for (int i = 0; i < 7; i++) begin
      txn($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].o0, tbl[i].o1, tbl[i].x0,
          tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].w, tbl[i].res);
    end

    // Long division with a fixed ALU answer.
    md_delay  = 20;
    force_en  = 1'b1;
    force_val = 16'h0302;
    txn("div20", 1'b0, 1'b1, 2'd0, 2'd3, 8'd0, 8'd0, 8'd50, 8'd6, 1, 16'h0302);
    force_en = 1'b0;

    // Reset in WAIT aborts the operation; a late done is ignored.
    do_reset();
    no_done = 1'b1;
    @(negedge clk);
    req0 = 1'b1; op0 = 2'd2; a0 = 8'd6; b0 = 8'd7;
    wait_gnt(g, n);
    chk("abort gnt", 64'(g), 64'd1);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("abort outputs", outs(), 64'd0);
    @(negedge clk) reset = 1'b0;
    last_m  = 1;
    no_done = 1'b0;
    stray_done = 1'b1;
    @(negedge clk) stray_done = 1'b0;
    acc = 1'b0;
    repeat (4) begin
      @(negedge clk);
      acc |= rsp_valid0 | rsp_valid1 | gnt0 | gnt1;
    end
    chk("abort no rsp", 64'(acc), 64'd0);
    txn("post abort", 1'b1, 1'b0, 2'd0, 2'd0, 8'd10, 8'd20, 8'd0, 8'd0, 0, 16'd30);

`ifdef ALU_ARB_TIMEOUT_EN
    do_reset();
    no_done = 1'b1;
    @(negedge clk);
    req0 = 1'b1; op0 = 2'd2; a0 = 8'd4; b0 = 8'd4;
    wait_gnt(g, n);
    req0 = 1'b0;
    wait_rsp(v, n, dn);
    chk("timeout rsp", 64'(v), 64'd1);
    chk("timeout err", 64'(rsp_err), 64'd1);
    chk("timeout res", 64'(rsp_result), 64'd0);
    chk("timeout lat", 64'(n), 64'd12);
    no_done = 1'b0;
    last_m  = 0;
`endif

    for (int i = 0; i < 30; i++) begin
      rr  = 2'($urandom_range(1, 3));
      ro0 = 2'($urandom);
      ro1 = 2'($urandom);
      rx0 = W'($urandom);
      ry0 = W'($urandom_range(1, 255));
      rx1 = W'($urandom);
      ry1 = W'($urandom_range(1, 255));
      md_delay = $urandom_range(1, 6);
      ew = (rr == 2'b11) ? 1 - last_m : (rr[1] ? 1 : 0);
      txn($sformatf("rnd%0d", i), rr[0], rr[1], ro0, ro1, rx0, ry0, rx1, ry1, ew,
          (ew != 0) ? ref_op(ro1, rx1, ry1) : ref_op(ro0, rx0, ry0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
